// File: rtl/fixed_point_multiplier_pipe.sv
// Signed fixed-point multiplier with selectable rounding, optional saturation and a stallable pipeline.
// Latency: PIPE_STAGES cycles from the accepting edge to out_valid; one product per cycle at full rate.
// Backpressure: a single global enable freezes every stage while out_valid & ~out_ready; in_ready follows it.
module fixed_point_multiplier_pipe #(
  parameter int A_WORD_LEN  = 9,
  parameter int A_FRAC_LEN  = 8,
  parameter int B_WORD_LEN  = 9,
  parameter int B_FRAC_LEN  = 8,
  parameter int C_WORD_LEN  = 10,
  parameter int C_FRAC_LEN  = 8,
  parameter int PIPE_STAGES = 2,
  parameter int ROUND_MODE  = 0,
  parameter int SATURATE    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_WORD_LEN-1:0] a,
  input  logic [B_WORD_LEN-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [C_WORD_LEN-1:0] c,
  output logic                  overflow
);

  // Full-precision product width and the binary-point shift from product to result.
  localparam int PW = A_WORD_LEN + B_WORD_LEN;
  localparam int SH = A_FRAC_LEN + B_FRAC_LEN - C_FRAC_LEN;
  localparam int SR = (SH > 0) ? SH : 0;
  localparam int SL = (SH < 0) ? -SH : 0;

  // Working width for the rescaled value: one guard bit for the rounding add,
  // room for a left shift, and never narrower than the result plus a sign bit
  // so the range comparison is always exact.
  localparam int RW0 = PW + 1 + SL;
  localparam int RW  = (RW0 > C_WORD_LEN + 1) ? RW0 : C_WORD_LEN + 1;

  // Half-LSB of the result, expressed in product units; zero when truncating
  // or when the result has at least as many fraction bits as the product.
  localparam int RND_POS = (SR > 0) ? SR - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (ROUND_MODE == 1 && SR > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RND_POS) : '0;

  // Representable range of c, sign-extended to the working width.
  localparam logic signed [RW-1:0] MAXV = {{(RW-C_WORD_LEN+1){1'b0}}, {(C_WORD_LEN-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-C_WORD_LEN+1){1'b1}}, {(C_WORD_LEN-1){1'b0}}};

  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
    $error("fixed_point_multiplier_pipe: PIPE_STAGES must be within 1..8");
  end
  if (ROUND_MODE != 0 && ROUND_MODE != 1) begin : g_bad_round
    $error("fixed_point_multiplier_pipe: ROUND_MODE must be 0 or 1");
  end

  logic                   en;
  logic [PIPE_STAGES-1:0] vld_q;
  logic signed [PW-1:0]   a_ext;
  logic signed [PW-1:0]   b_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   last_prod;
  logic signed [RW-1:0]   ext;
  logic signed [RW-1:0]   sum;
  logic signed [RW-1:0]   r;
  logic                   ovf_nxt;
  logic [C_WORD_LEN-1:0]  c_nxt;

  // The whole pipe moves together: it may advance whenever the output slot is
  // empty or being drained this cycle. Nothing here depends on in_valid.
  assign en        = ~vld_q[PIPE_STAGES-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[PIPE_STAGES-1];

  // Exact product: both operands sign-extended to the full product width first.
  assign a_ext = PW'($signed(a));
  assign b_ext = PW'($signed(b));
  assign prod  = a_ext * b_ext;

  if (PIPE_STAGES == 1) begin : g_one
    // Single stage: multiply, rescale and range-check all feed the output register.
    assign last_prod = prod;
  end else begin : g_multi
    logic signed [PW-1:0] prod_q [PIPE_STAGES-1];

    // Carry the raw product through every stage except the last.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_STAGES - 1; i++) prod_q[i] <= '0;
      end else if (en) begin
        prod_q[0] <= prod;
        for (int i = 1; i < PIPE_STAGES - 1; i++) prod_q[i] <= prod_q[i-1];
      end
    end

    assign last_prod = prod_q[PIPE_STAGES-2];
  end

  // Valid bits shift alongside the data; an idle input cycle becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Rescale to the output binary point, then clamp or wrap into C_WORD_LEN bits.
  always_comb begin
    ext     = RW'(last_prod);
    sum     = ext + RND;
    r       = (sum >>> SR) <<< SL;
    ovf_nxt = (r > MAXV) || (r < MINV);
    if (ovf_nxt && SATURATE == 1) begin
      c_nxt = r[RW-1] ? MINV[C_WORD_LEN-1:0] : MAXV[C_WORD_LEN-1:0];
    end else begin
      c_nxt = r[C_WORD_LEN-1:0];
    end
  end

  // Final stage register: holds c and overflow steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c        <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      c        <= c_nxt;
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: doc/fixed_point_multiplier_pipe.md
Name: fixed_point_multiplier_pipe

Overview:
- Pipelined, stall-capable signed fixed-point multiplier; next generation of the team's combinational fixed-point multiplier.
- Adds selectable rounding, optional saturation with an overflow flag, configurable pipeline depth, and a valid/ready handshake on both sides.
- Sits between FIR tap registers and the accumulator tree; one product per cycle at full throughput.

Parameters:
A_WORD_LEN, 9, total width of operand a (two's complement)
A_FRAC_LEN, 8, fractional bits of a
B_WORD_LEN, 9, total width of operand b
B_FRAC_LEN, 8, fractional bits of b
C_WORD_LEN, 10, total width of result c
C_FRAC_LEN, 8, fractional bits of c
PIPE_STAGES, 2, register stages from input to output; legal range 1 to 8
ROUND_MODE, 0, 0 = truncate (floor); 1 = round half up (add half-LSB, then floor)
SATURATE, 1, 1 = clamp to the range of c on overflow; 0 = wrap (keep the low C_WORD_LEN bits)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  a and b are valid this cycle
in_ready  output  1  block accepts the input this cycle
a  input  A_WORD_LEN  signed operand
b  input  B_WORD_LEN  signed operand
out_valid  output  1  c and overflow are valid
out_ready  input  1  downstream accepts the output
c  output  C_WORD_LEN  signed result
overflow  output  1  result exceeded the range of c; qualified by out_valid

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits, c and overflow clear to 0 immediately. Any in-flight data is discarded. First acceptance is possible on the first rising edge after rst deasserts.
- Product: P = a*b, computed full-width at A_WORD_LEN+B_WORD_LEN bits with no loss. PF = A_FRAC_LEN+B_FRAC_LEN. Shift s = PF - C_FRAC_LEN.
- s > 0:
  - ROUND_MODE 0: R = P >>> s (arithmetic shift).
  - ROUND_MODE 1: R = (P + 2^(s-1)) >>> s. The addition is one bit wider than P so it cannot overflow.
- s <= 0: R = P << (-s). The zero fill is exact and ROUND_MODE has no effect.
- Range check: overflow = 1 if R > 2^(C_WORD_LEN-1)-1 or R < -2^(C_WORD_LEN-1).
  - SATURATE 1: c = max positive or min negative, matching the sign of R.
  - SATURATE 0: c = R[C_WORD_LEN-1:0].
  - overflow is flagged in both modes.
- No constraint is placed on the parameter ratio; overflow is the only range protection.
- Pipeline:
  - PIPE_STAGES register stages, each holding a valid bit and data.
  - Multiply is in stage 1. Rounding and saturation are in the last stage (the same stage when PIPE_STAGES = 1).
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en, combinational. No combinational path from in_valid to out_valid.
  - When en = 1, all stages advance. Stage-1 valid loads in_valid, so a bubble enters when in_valid = 0.
  - When en = 0, every stage holds. c and overflow stay stable while out_valid & ~out_ready.
- Latency and throughput:
  - Latency is exactly PIPE_STAGES cycles from the accepting edge to out_valid, with no stalls.
  - Throughput is 1 per cycle while out_ready = 1.
  - Ordering is strictly FIFO. No sample is dropped or duplicated.
- Accept-and-emit in the same cycle (in_valid & in_ready with out_valid & out_ready) is a normal advance.
- Output data while out_valid = 0 is don't-care. The bench checks only valid beats.
- Elaboration error if PIPE_STAGES is outside 1 to 8, or if ROUND_MODE is not 0 or 1.

Test Plan:
1. Defaults; a=0x080, b=0x080, out_ready=1 -> out_valid exactly 2 cycles later, c=0x040, overflow=0.
2. Rounding, defaults; a=0x001, b=0x080.
   - ROUND_MODE 0 -> c=0x000.
   - ROUND_MODE 1 -> c=0x001.
   - Then a=0x1FF, b=0x080: ROUND_MODE 0 -> c=0x3FF; ROUND_MODE 1 -> c=0x000.
3. Overflow, C_WORD_LEN=9; a=0x100, b=0x100 (-1 * -1).
   - SATURATE 1 -> c=0x0FF, overflow=1.
   - SATURATE 0 -> c=0x100, overflow=1.
4. Backpressure; stream 10 random pairs back-to-back; hold out_ready=0 for 5 cycles mid-stream.
   - in_ready falls in the same cycle.
   - c holds stable while stalled.
   - All 10 results match the golden model, in order.
5. Reset mid-operation; assert rst asynchronously (between edges) with 2 samples in flight.
   - out_valid, c and overflow drop to 0 immediately.
   - No stale output appears after release.
   - The next sample has normal latency.
6. PIPE_STAGES=1 and PIPE_STAGES=8; 1000 random pairs with random out_ready.
   - Latency equals PIPE_STAGES.
   - Every output bit-exact against the reference model.
